// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared definitions for the scan test controller: FSM state
//                encoding, default chain length and a saturating increment.
//  Revision    : 1.0  initial release
// ============================================================================
package scan_pkg;

  localparam int DEFAULT_CHAIN_LEN = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_resp_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : scan_resp_cmp
//  Description : Response shift register fed from the chain's serial output,
//                masked compare against the expected response and the
//                session pass/fail statistics.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                i_sample, i_so      shift i_so into the response register
//                i_compare           compare the (just completed) response
//                i_clear             clear statistics at session start
//                i_exp, i_mask       expected value / care mask
//                i_idx               index of the pattern being compared
//                o_fail_any, o_fail_count, o_first_fail_idx  statistics
//  Revision    : 1.0  initial release
// ============================================================================
module scan_resp_cmp
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sample,
  input  logic                 i_so,
  input  logic                 i_compare,
  input  logic                 i_clear,
  input  logic [CHAIN_LEN-1:0] i_exp,
  input  logic [CHAIN_LEN-1:0] i_mask,
  input  logic [STAT_W-1:0]    i_idx,
  output logic                 o_fail_any,
  output logic [STAT_W-1:0]    o_fail_count,
  output logic [STAT_W-1:0]    o_first_fail_idx
);

  localparam logic [STAT_W-1:0] C_STAT_MAX = {STAT_W{1'b1}};

  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 fail_any_q, fail_any_d;
  logic [STAT_W-1:0]    fail_count_q, fail_count_d;
  logic [STAT_W-1:0]    first_idx_q, first_idx_d;
  logic                 w_fail;

  always_comb begin
    resp_d       = resp_q;
    fail_any_d   = fail_any_q;
    fail_count_d = fail_count_q;
    first_idx_d  = first_idx_q;

    // The first bit shifted out lands in the MSB after CHAIN_LEN shifts.
    if (i_sample) begin
      resp_d = {resp_q[CHAIN_LEN-2:0], i_so};
    end

    // The compare strobe coincides with the final sample, so compare the
    // value that includes it.
    w_fail = |((resp_d ^ i_exp) & i_mask);

    if (i_clear) begin
      fail_any_d   = 1'b0;
      fail_count_d = '0;
      first_idx_d  = '0;
    end else if (i_compare && w_fail) begin
      fail_any_d   = 1'b1;
      fail_count_d = STAT_W'(sat_inc(32'(fail_count_q), 32'(C_STAT_MAX)));
      if (!fail_any_q) begin
        first_idx_d = i_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q       <= '0;
      fail_any_q   <= 1'b0;
      fail_count_q <= '0;
      first_idx_q  <= '0;
    end else begin
      resp_q       <= resp_d;
      fail_any_q   <= fail_any_d;
      fail_count_q <= fail_count_d;
      first_idx_q  <= first_idx_d;
    end
  end

  assign o_fail_any       = fail_any_q;
  assign o_fail_count     = fail_count_q;
  assign o_first_fail_idx = first_idx_q;

endmodule
`default_nettype wire

// File: rtl/scan_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_test_ctrl
//  Description : Scan chain sequencer. Loads each pattern serially (MSB
//                first), pulses capture for one cycle, and unloads the
//                response while the next pattern loads.
//  Ports       : C, global_reset            clock, synchronous reset
//                pat_valid/pat_ready        pattern handshake
//                pat_data/exp/mask/last     pattern contents
//                So                         chain serial output
//                NbarT, Si, CE              chain control (registered)
//                busy, done                 session status
//                fail_any, fail_count, first_fail_idx  session statistics
//  Revision    : 1.0  initial release
// ============================================================================
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1),
  parameter int STAT_W    = 16
) (
  input  logic                 C,
  input  logic                 global_reset,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] pat_exp,
  input  logic [CHAIN_LEN-1:0] pat_mask,
  input  logic                 pat_last,
  input  logic                 So,
  output logic                 NbarT,
  output logic                 Si,
  output logic                 CE,
  output logic                 busy,
  output logic                 done,
  output logic                 fail_any,
  output logic [STAT_W-1:0]    fail_count,
  output logic [STAT_W-1:0]    first_fail_idx
);

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] data_q, data_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic [CHAIN_LEN-1:0] exp_prev_q, exp_prev_d;
  logic [CHAIN_LEN-1:0] mask_prev_q, mask_prev_d;
  logic                 last_q, last_d;
  logic                 have_prev_q, have_prev_d;
  logic [STAT_W-1:0]    pat_idx_q, pat_idx_d;
  logic [STAT_W-1:0]    pat_idx_prev_q, pat_idx_prev_d;
  logic                 nbart_q, nbart_d;
  logic                 si_q, si_d;
  logic                 ce_q, ce_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] w_data_sh;
  logic                 w_accept, w_shift_end, w_sample, w_compare, w_clear;

  // Ready is decoded from the current state; during CAPTURE a new pattern
  // may be taken only when the current one does not close the session.
  always_comb begin
    pat_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: pat_ready = 1'b1;
      ST_CAPTURE:       pat_ready = ~last_q;
      default:          pat_ready = 1'b0;
    endcase
  end

  assign w_accept    = pat_valid & pat_ready;
  assign w_shift_end = (cnt_q == C_LAST_BIT);
  assign w_sample    = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
  assign w_compare   = w_shift_end &&
                       (((state_q == ST_SHIFT) && have_prev_q) || (state_q == ST_UNLOAD));
  assign w_clear     = (state_q == ST_IDLE) && w_accept;

  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    exp_d          = exp_q;
    mask_d         = mask_q;
    last_d         = last_q;
    exp_prev_d     = exp_prev_q;
    mask_prev_d    = mask_prev_q;
    have_prev_d    = have_prev_q;
    pat_idx_d      = pat_idx_q;
    pat_idx_prev_d = pat_idx_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d     = ST_SHIFT;
          have_prev_d = 1'b0;
          pat_idx_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (w_shift_end) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        exp_prev_d     = exp_q;
        mask_prev_d    = mask_q;
        have_prev_d    = 1'b1;
        pat_idx_prev_d = pat_idx_q;
        pat_idx_d      = pat_idx_q + STAT_W'(1);
        if (last_q)        state_d = ST_UNLOAD;
        else if (w_accept) state_d = ST_SHIFT;
        else               state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_accept) state_d = ST_SHIFT;
      end
      ST_UNLOAD: begin
        if (w_shift_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (w_accept) begin
      data_d = pat_data;
      exp_d  = pat_exp;
      mask_d = pat_mask;
      last_d = pat_last;
    end

    // Counter restarts on entry to a shifting state and advances while in it.
    if ((state_d == ST_SHIFT) || (state_d == ST_UNLOAD)) begin
      cnt_d = (state_q == state_d) ? cnt_q + CNT_W'(1) : '0;
    end else begin
      cnt_d = '0;
    end

    // Outputs are decoded from the next state so they line up with it.
    w_data_sh = data_d << cnt_d;
    nbart_d   = (state_d == ST_SHIFT) || (state_d == ST_UNLOAD);
    ce_d      = (state_d == ST_CAPTURE);
    si_d      = (state_d == ST_SHIFT) ? w_data_sh[CHAIN_LEN-1] : 1'b0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge C) begin
    if (global_reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      data_q         <= '0;
      exp_q          <= '0;
      mask_q         <= '0;
      last_q         <= 1'b0;
      exp_prev_q     <= '0;
      mask_prev_q    <= '0;
      have_prev_q    <= 1'b0;
      pat_idx_q      <= '0;
      pat_idx_prev_q <= '0;
      nbart_q        <= 1'b0;
      si_q           <= 1'b0;
      ce_q           <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      exp_q          <= exp_d;
      mask_q         <= mask_d;
      last_q         <= last_d;
      exp_prev_q     <= exp_prev_d;
      mask_prev_q    <= mask_prev_d;
      have_prev_q    <= have_prev_d;
      pat_idx_q      <= pat_idx_d;
      pat_idx_prev_q <= pat_idx_prev_d;
      nbart_q        <= nbart_d;
      si_q           <= si_d;
      ce_q           <= ce_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign NbarT = nbart_q;
  assign Si    = si_q;
  assign CE    = ce_q;
  assign busy  = busy_q;
  assign done  = done_q;

  scan_resp_cmp #(
    .CHAIN_LEN (CHAIN_LEN),
    .STAT_W    (STAT_W)
  ) u_resp_cmp (
    .clk              (C),
    .rst              (global_reset),
    .i_sample         (w_sample),
    .i_so             (So),
    .i_compare        (w_compare),
    .i_clear          (w_clear),
    .i_exp            (exp_prev_q),
    .i_mask           (mask_prev_q),
    .i_idx            (pat_idx_prev_q),
    .o_fail_any       (fail_any),
    .o_fail_count     (fail_count),
    .o_first_fail_idx (first_fail_idx)
  );

endmodule
`default_nettype wire

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
- Sequences a scan chain built from library dff cells.
- Drives the chain's NbarT (scan enable), Si (serial in) and CE (capture enable) pins.
- Serially loads each test pattern, issues a one-cycle capture, then shifts the response out and compares it against the expected value under a care mask.
- Unload of pattern k overlaps with load of pattern k+1. Patterns arrive over a valid/ready handshake; pass/fail statistics are reported per session.

Parameters:
- CHAIN_LEN, 16, number of dff cells in the chain (>= 2).
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter.
- STAT_W, 16, width of the pattern index and fail counter.

Ports:
- C  in  1  clock; the chain dffs share it.
- global_reset  in  1  synchronous, active-high reset.
- pat_valid  in  1  pattern offered.
- pat_ready  out  1  controller can accept a pattern.
- pat_data  in  CHAIN_LEN  stimulus; bit i is the value for chain cell i (cell 0 is fed by Si, cell CHAIN_LEN-1 drives So).
- pat_exp  in  CHAIN_LEN  expected captured value per cell.
- pat_mask  in  CHAIN_LEN  1 = compare this bit, 0 = don't care.
- pat_last  in  1  this pattern ends the session.
- So  in  1  serial out of the last chain cell.
- NbarT  out  1  scan enable to all chain dffs.
- Si  out  1  serial in to cell 0.
- CE  out  1  capture enable to all chain dffs.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- fail_any  out  1  sticky fail flag, cleared at session start.
- fail_count  out  STAT_W  failing patterns, saturating.
- first_fail_idx  out  STAT_W  0-based index of the first failing pattern; valid when fail_any=1.

Behaviour:
- Reset (synchronous, global_reset sampled at the rising edge of C):
  - state=IDLE; NbarT=0, CE=0, Si=0, busy=0, done=0.
  - fail_any=0, fail_count=0, first_fail_idx=0; have_prev=0.
  - Reset mid-session abandons the session with no done pulse; the chain contents are left undefined.
- Outputs NbarT, Si and CE are registered. They are decoded from the next state so they are valid in the same cycle the state is entered.
- IDLE:
  - pat_ready=1.
  - On handshake: latch data/exp/mask/last, clear fail_any, fail_count and pat_idx, set have_prev=0, go to SHIFT.
- SHIFT (CHAIN_LEN cycles, k=0..CHAIN_LEN-1):
  - NbarT=1, CE=0, Si=data[CHAIN_LEN-1-k]; MSB first.
  - At each edge, So is shifted into resp at position CHAIN_LEN-1-k.
  - After cycle CHAIN_LEN-1: if have_prev, compare the previous pattern, then go to CAPTURE.
- CAPTURE (1 cycle):
  - NbarT=0, CE=1.
  - Current exp/mask/last move to the prev registers; have_prev=1; pat_idx_prev=pat_idx; pat_idx increments.
  - If last is set: go to UNLOAD with pat_ready=0.
  - Otherwise pat_ready=1. A handshake this cycle goes to SHIFT with no idle gap; without one, go to WAIT.
- WAIT:
  - NbarT=0, CE=0, pat_ready=1.
  - Handshake goes to SHIFT. The chain holds because CE=0.
- UNLOAD (CHAIN_LEN cycles):
  - NbarT=1, CE=0, Si=0; So is sampled as in SHIFT.
  - Compare at the end, then go to DONE.
- DONE: done=1 for one cycle, busy=0 on exit, go to IDLE.
- busy=1 in every state except IDLE.
- Compare rule: fail = |((resp ^ exp_prev) & mask_prev). On fail:
  - fail_count += 1, saturating at 2^STAT_W-1.
  - On the first fail of the session, first_fail_idx = pat_idx_prev.
  - fail_any=1.
- A mask of all zeros never fails.
- pat_data, pat_exp, pat_mask and pat_last are ignored unless pat_valid & pat_ready. pat_ready is 0 in SHIFT, UNLOAD and DONE.
- Latency: accept in IDLE → done pulse in cycle 2*CHAIN_LEN+2 after the accept edge, for a single pattern.

Decomposition:
- Shared package (scan_pkg):
  - state encoding constants ST_IDLE, ST_SHIFT, ST_CAPTURE, ST_WAIT, ST_UNLOAD, ST_DONE;
  - the default chain length;
  - the saturating-increment function.
- One natural sub-module: scan_resp_cmp. It holds the response shift register plus the masked compare and statistic update, and is driven by sample/compare strobes from the FSM.

Test Plan:
- Single pattern, CHAIN_LEN=4, chain of dff cells with capture D=~Q:
  - Stimulus: data=4'b1011, exp=4'b0100, mask=4'b1111, last=1.
  - Required: Si sequence 1,0,1,1; CE high exactly 1 cycle; done at cycle 10 after accept; fail_any=0, fail_count=0.
- Same single-pattern setup with exp=4'b0110:
  - Required: fail_any=1, fail_count=1, first_fail_idx=0.
  - Rerun with mask=4'b1101 → no fail.
- Three back-to-back patterns, pat_valid held high:
  - Required: no WAIT cycles; NbarT low only in the 3 capture cycles; done at cycle 3*(CHAIN_LEN+1)+CHAIN_LEN+1 = 20 after the first accept.
  - With pattern index 1 corrupted: fail_count=1, first_fail_idx=1.
- pat_valid dropped for 5 cycles after the first CAPTURE:
  - Required: WAIT holds with NbarT=0, CE=0 and the chain unchanged; the second pattern result is still correct.
- global_reset asserted mid-SHIFT:
  - Required: next cycle NbarT=0, CE=0, busy=0, pat_ready=1; no done pulse.
  - A new session then runs cleanly with stats cleared.
- Fail counter saturation, STAT_W=2, 5 failing patterns:
  - Required: fail_count=3 (no wrap); first_fail_idx=0.
